mem_access_unit: RTL and testbench

- Load/store unit directly upstream of the 8-bit data memory; the only master of that memory's address, write_data, mem_write and mem_read pins.
- Accepts one load or store request per transaction from the CPU execute stage over a valid/ready handshake.
- Computes the effective address as base + signed offset, runs exactly one memory access, and returns load data or store completion over a valid/ready response channel.

---
 rtl/mem_access_unit_if.sv | 36 +++
 rtl/mem_access_unit.sv | 114 +++++++++++
 tb/tb_mem_access_unit.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory bus bundle for the load/store unit.
// The unit connects through the slave modport; the CPU/memory side uses master.
interface mem_access_unit_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_base;
  logic [ADDR_W-1:0] req_offset;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_fault;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  req_valid, req_write, req_base, req_offset, req_wdata,
    input  resp_ready, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_address, mem_write_data, mem_write, mem_read
  );

  modport master (
    output req_valid, req_write, req_base, req_offset, req_wdata,
    output resp_ready, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_address, mem_write_data, mem_write, mem_read
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: one base+offset memory access per request, fully registered outputs.
// Optional store write-protection above PROT_BASE is enabled by defining LSU_PROT_EN.
module mem_access_unit #(
  parameter int              DATA_W    = 8,
  parameter int              ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] PROT_BASE = 'hF0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_access_unit_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state, state_nxt;
  logic              write_q, write_nxt;
  logic              req_ready_nxt;
  logic              resp_valid_nxt;
  logic [DATA_W-1:0] resp_rdata_nxt;
  logic              resp_fault_nxt;
  logic [ADDR_W-1:0] mem_address_nxt;
  logic [DATA_W-1:0] mem_write_data_nxt;
  logic              mem_write_nxt;
  logic              mem_read_nxt;
  logic [ADDR_W-1:0] ea;

  // Offset is two's complement; modular addition wraps the same way for either sign.
  function automatic logic [ADDR_W-1:0] eff_addr(input logic [ADDR_W-1:0] base,
                                                 input logic signed [ADDR_W-1:0] off);
    return base + $unsigned(off);
  endfunction

  assign ea = eff_addr(bus.req_base, bus.req_offset);

  always_comb begin
    state_nxt          = state;
    write_nxt          = write_q;
    resp_valid_nxt     = bus.resp_valid;
    resp_rdata_nxt     = bus.resp_rdata;
    resp_fault_nxt     = bus.resp_fault;
    mem_address_nxt    = bus.mem_address;
    mem_write_data_nxt = bus.mem_write_data;
    mem_write_nxt      = 1'b0;
    mem_read_nxt       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          mem_address_nxt    = ea;
          mem_write_data_nxt = bus.req_wdata;
          write_nxt          = bus.req_write;
`ifdef LSU_PROT_EN
          if (bus.req_write && (ea >= PROT_BASE)) begin
            // Protected store: skip the memory cycle and fault straight away.
            state_nxt      = RESP;
            resp_valid_nxt = 1'b1;
            resp_fault_nxt = 1'b1;
            resp_rdata_nxt = '0;
          end else begin
            mem_write_nxt = bus.req_write;
            mem_read_nxt  = !bus.req_write;
            state_nxt     = ACCESS;
          end
`else
          mem_write_nxt = bus.req_write;
          mem_read_nxt  = !bus.req_write;
          state_nxt     = ACCESS;
`endif
        end
      end
      ACCESS: begin
        resp_valid_nxt = 1'b1;
        resp_fault_nxt = 1'b0;
        resp_rdata_nxt = write_q ? '0 : bus.mem_read_data;
        state_nxt      = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_nxt = 1'b0;
          resp_fault_nxt = 1'b0;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    req_ready_nxt = (state_nxt == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      write_q            <= 1'b0;
      bus.req_ready      <= 1'b1;
      bus.resp_valid     <= 1'b0;
      bus.resp_rdata     <= '0;
      bus.resp_fault     <= 1'b0;
      bus.mem_address    <= '0;
      bus.mem_write_data <= '0;
      bus.mem_write      <= 1'b0;
      bus.mem_read       <= 1'b0;
    end else begin
      state              <= state_nxt;
      write_q            <= write_nxt;
      bus.req_ready      <= req_ready_nxt;
      bus.resp_valid     <= resp_valid_nxt;
      bus.resp_rdata     <= resp_rdata_nxt;
      bus.resp_fault     <= resp_fault_nxt;
      bus.mem_address    <= mem_address_nxt;
      bus.mem_write_data <= mem_write_data_nxt;
      bus.mem_write      <= mem_write_nxt;
      bus.mem_read       <= mem_read_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural 256-byte data memory.
// Build with +define+LSU_PROT_EN to exercise the write-protection variant.
module tb_mem_access_unit;

  typedef struct packed {
    logic [7:0] rdata;
    logic       fault;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   overlap = 0;
  exp_t sb[$];
  logic [7:0] mem     [256] = '{default: 8'h00};
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  logic [7:0] held;

  mem_access_unit_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  mem_access_unit #(.DATA_W(8), .ADDR_W(8), .PROT_BASE(8'hF0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_read_data = bus.mem_read ? mem[bus.mem_address] : 8'h00;
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_address] <= bus.mem_write_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: expected response computed when the request is issued.
  task automatic push_exp(input bit wr, input logic [7:0] base, input logic [7:0] off,
                          input logic [7:0] wd);
    logic [7:0] a;
    exp_t e;
    bit prot;
    a = base + off;
    prot = 1'b0;
`ifdef LSU_PROT_EN
    prot = wr && (a >= 8'hF0);
`endif
    if (wr) begin
      if (!prot) ref_mem[a] = wd;
      e.rdata = 8'h00;
      e.fault = prot;
    end else begin
      e.rdata = ref_mem[a];
      e.fault = 1'b0;
    end
    sb.push_back(e);
  endtask

  // Returns 1 ns after the acceptance edge.
  task automatic do_req(input bit wr, input logic [7:0] base, input logic [7:0] off,
                        input logic [7:0] wd);
    @(negedge clk);
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    chk("req_ready_wait", bus.req_ready, 1'b1);
    push_exp(wr, base, off, wd);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_base   = base;
    bus.req_offset = off;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      done = bus.req_ready && (sb.size() == 0);
    end
    chk("idle_timeout", done, 1'b1);
  endtask

  always @(negedge clk) begin
    if (bus.mem_read && bus.mem_write) overlap++;
    if (rst_n && bus.resp_valid && bus.resp_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_resp", 1'b1, 1'b0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_rdata", bus.resp_rdata, e.rdata);
        chk("sb_fault", bus.resp_fault, e.fault);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_base   = 8'h00;
    bus.req_offset = 8'h00;
    bus.req_wdata  = 8'h00;
    bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_resp_rdata", bus.resp_rdata, 8'h00);
    chk("rst_resp_fault", bus.resp_fault, 1'b0);
    chk("rst_mem_address", bus.mem_address, 8'h00);
    chk("rst_mem_wdata", bus.mem_write_data, 8'h00);
    chk("rst_mem_write", bus.mem_write, 1'b0);
    chk("rst_mem_read", bus.mem_read, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload [0x0A]=0x05 through the unit itself
    do_req(1'b1, 8'h08, 8'h02, 8'h05);
    chk("pre_mem_write", bus.mem_write, 1'b1);
    chk("pre_mem_address", bus.mem_address, 8'h0A);
    wait_idle();
    chk("pre_mem_0a", mem[8'h0A], 8'h05);

    // Load with latency and strobe checks
    do_req(1'b0, 8'h08, 8'h02, 8'h00);
    chk("ld_mem_read_on", bus.mem_read, 1'b1);
    chk("ld_mem_write_off", bus.mem_write, 1'b0);
    chk("ld_mem_address", bus.mem_address, 8'h0A);
    chk("ld_req_ready_low", bus.req_ready, 1'b0);
    chk("ld_resp_valid_early", bus.resp_valid, 1'b0);
    @(posedge clk); #1;
    chk("ld_mem_read_off", bus.mem_read, 1'b0);
    chk("ld_resp_valid", bus.resp_valid, 1'b1);
    chk("ld_resp_rdata", bus.resp_rdata, 8'h05);
    chk("ld_resp_fault", bus.resp_fault, 1'b0);
    wait_idle();

    // Store then load back
    do_req(1'b1, 8'h20, 8'h00, 8'h3C);
    chk("st_mem_write_on", bus.mem_write, 1'b1);
    chk("st_mem_wdata", bus.mem_write_data, 8'h3C);
    @(posedge clk); #1;
    chk("st_mem_write_off", bus.mem_write, 1'b0);
    chk("st_resp_valid", bus.resp_valid, 1'b1);
    chk("st_resp_rdata", bus.resp_rdata, 8'h00);
    do_req(1'b0, 8'h20, 8'h00, 8'h00);
    wait_idle();

    // Address wrap in both directions
    do_req(1'b1, 8'hFE, 8'h05, 8'h77);
    chk("wrap_st_addr", bus.mem_address, 8'h03);
    wait_idle();
    chk("wrap_mem_03", mem[8'h03], 8'h77);
    do_req(1'b0, 8'h02, 8'hFD, 8'h00);
    chk("wrap_ld_addr", bus.mem_address, 8'hFF);
    wait_idle();

    // Backpressure, with a competing request held pending
    bus.resp_ready = 1'b0;
    do_req(1'b0, 8'h02, 8'h01, 8'h00);
    @(posedge clk); #1;
    chk("bp_resp_valid", bus.resp_valid, 1'b1);
    held = bus.resp_rdata;
    chk("bp_rdata", held, 8'h77);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_base   = 8'h50;
    bus.req_offset = 8'h00;
    bus.req_wdata  = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", bus.resp_valid, 1'b1);
      chk("bp_hold_rdata", bus.resp_rdata, held);
      chk("bp_hold_ready", bus.req_ready, 1'b0);
      chk("bp_no_accept", bus.mem_write, 1'b0);
    end
    push_exp(1'b1, 8'h50, 8'h00, 8'h55);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", bus.resp_valid, 1'b0);
    chk("bp_release_ready", bus.req_ready, 1'b1);
    chk("bp_not_same_edge", bus.mem_write, 1'b0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("bp_accept_write", bus.mem_write, 1'b1);
    chk("bp_accept_addr", bus.mem_address, 8'h50);
    wait_idle();
    chk("bp_mem_50", mem[8'h50], 8'h55);

    // Protected region
    do_req(1'b1, 8'hF0, 8'h03, 8'hA5);
`ifdef LSU_PROT_EN
    chk("prot_no_write", bus.mem_write, 1'b0);
    chk("prot_resp_valid", bus.resp_valid, 1'b1);
    chk("prot_resp_fault", bus.resp_fault, 1'b1);
    wait_idle();
    chk("prot_mem_f3", mem[8'hF3], 8'h00);
`else
    chk("noprot_write", bus.mem_write, 1'b1);
    wait_idle();
    chk("noprot_mem_f3", mem[8'hF3], 8'hA5);
`endif
    do_req(1'b1, 8'hEF, 8'h00, 8'h5A);
    chk("edge_ef_write", bus.mem_write, 1'b1);
    wait_idle();
    chk("edge_mem_ef", mem[8'hEF], 8'h5A);

    // Reset while a store is in ACCESS
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_base   = 8'h40;
    bus.req_offset = 8'h00;
    bus.req_wdata  = 8'h99;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("mid_write_on", bus.mem_write, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_write_drop", bus.mem_write, 1'b0);
    chk("mid_read", bus.mem_read, 1'b0);
    chk("mid_req_ready", bus.req_ready, 1'b1);
    chk("mid_resp_valid", bus.resp_valid, 1'b0);
    chk("mid_mem_address", bus.mem_address, 8'h00);
    chk("mid_mem_wdata", bus.mem_write_data, 8'h00);
    chk("mid_resp_rdata", bus.resp_rdata, 8'h00);
    @(posedge clk); #1;
    chk("mid_mem_40", mem[8'h40], 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_no_resp", bus.resp_valid, 1'b0);

    chk("sb_drained", sb.size(), 0);
    chk("strobe_overlap", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
